instr_fetch_unit: RTL and testbench

Instruction fetch front-end for the RV32I core: owns the PC, issues in-order requests to instruction memory through a credit-limited handshake, and buffers returned words in a small prefetch queue. Its head entry drives the instruction word and its decode fields (Op, funct3, funct7) into the control unit and datapath. Branch/jump redirects from execute flush the queue and squash in-flight returns.

---
 rtl/ifu_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 14 +
 rtl/ifu_fifo.sv | 48 ++++
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 tb/tb_instr_fetch_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_W   = 7;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/return handshake between the fetch unit and imem.
interface instr_fetch_unit_if;
    import ifu_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/ifu_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of {instr, pc} with flush.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]  count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front-end: PC, credit-limited imem requests, prefetch queue, redirect squash.
// Optional FETCH_BYPASS_EN: zero-latency forward of a return into an empty queue.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_fetch_unit_if.master        imem,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [XLEN-1:0]           Instr,
    output logic [XLEN-1:0]           PC,
    output logic [XLEN-1:0]           PCPlus4,
    output logic [OPCODE_W-1:0]       Op,
    output logic [FUNCT3_W-1:0]       funct3,
    output logic [FUNCT7_W-1:0]       funct7
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q;
    logic [CW-1:0]   outstanding_q, discard_q;
    logic [CW-1:0]   count;
    logic [CW:0]     inflight;
    fetch_entry_t    head, ret_entry, out_entry;
    logic            fifo_empty, grant, ret_valid, ret_drop, ret_keep;
    logic            bypass, pop, fifo_pop, push;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign inflight  = {1'b0, outstanding_q} + {1'b0, count};
    assign imem.req  = rst && (inflight < DEPTH_C) && !redirect_valid;
    assign imem.addr = fetch_pc_q;
    assign grant     = imem.req && imem.gnt;

    // Returns with nothing outstanding are protocol errors and ignored.
    assign ret_valid = imem.rvalid && (outstanding_q != '0);
    assign ret_drop  = ret_valid && (discard_q != '0);
    assign ret_keep  = ret_valid && (discard_q == '0);

    // In-order returns: oldest live request was issued outstanding words back.
    assign ret_entry.instr = imem.rdata;
    assign ret_entry.pc    = fetch_pc_q - XLEN'({outstanding_q, 2'b00});

    assign fifo_empty = (count == '0);

    always_comb begin
        bypass    = 1'b0;
        out_entry = head;
`ifdef FETCH_BYPASS_EN
        if (fifo_empty && ret_keep) begin
            bypass    = 1'b1;
            out_entry = ret_entry;
        end
`endif
    end

    assign instr_valid = !fifo_empty || bypass;
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign fifo_pop    = pop && !fifo_empty;
    assign push        = ret_keep && !redirect_valid && !(bypass && pop);

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (ret_entry),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_q + CW'(grant) - CW'(ret_valid);
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
                discard_q  <= outstanding_q - CW'(ret_valid);
            end else begin
                if (grant) fetch_pc_q <= fetch_pc_q + 32'd4;
                discard_q <= discard_q - CW'(ret_drop);
            end
        end
    end

    always_comb begin
        Instr   = NOP_INSTR;
        PC      = '0;
        PCPlus4 = '0;
        if (instr_valid) begin
            Instr   = out_entry.instr;
            PC      = out_entry.pc;
            PCPlus4 = out_entry.pc + 32'd4;
        end
    end

    assign Op     = Instr[OPCODE_LSB +: OPCODE_W];
    assign funct3 = Instr[FUNCT3_LSB +: FUNCT3_W];
    assign funct7 = Instr[FUNCT7_LSB +: FUNCT7_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, reset mid-burst, random vs queue model.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [31:0] W0 = 32'h0050_0093;
    localparam logic [31:0] W1 = 32'h4020_8133;
    localparam logic [31:0] W2 = 32'h0020_a1a3;
    localparam logic [31:0] WS = 32'hdead_beef;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] Instr, PC, PCPlus4;
    logic [6:0]  Op, funct7;
    logic [2:0]  funct3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if imem ();

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .Instr          (Instr),
        .PC             (PC),
        .PCPlus4        (PCPlus4),
        .Op             (Op),
        .funct3         (funct3),
        .funct7         (funct7)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic ev, input logic [31:0] ei_in,
                              input logic [31:0] ep_in);
        logic [31:0] ei, ep, epp;
        ei  = ev ? ei_in : 32'h0000_0013;
        ep  = ev ? ep_in : 32'h0;
        epp = ev ? ep_in + 32'd4 : 32'h0;
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'(ev));
        chk({tag, " Instr"}, Instr, ei);
        chk({tag, " PC"}, PC, ep);
        chk({tag, " PCPlus4"}, PCPlus4, epp);
        chk({tag, " Op"}, 32'(Op), 32'(ei[6:0]));
        chk({tag, " funct3"}, 32'(funct3), 32'(ei[14:12]));
        chk({tag, " funct7"}, 32'(funct7), 32'(ei[31:25]));
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e37_79b9) ^ {a[15:0], a[31:16]};
    endfunction

    typedef struct {
        logic        gnt, rvalid, ready, redir;
        logic [31:0] rdata, rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr, e_pc;
    } vec_t;

    function automatic vec_t mk(input logic gnt, input logic rvalid, input logic ready,
                                input logic redir, input logic [31:0] rdata,
                                input logic [31:0] rpc, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_pc);
        vec_t v;
        v.gnt = gnt; v.rvalid = rvalid; v.ready = ready; v.redir = redir;
        v.rdata = rdata; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    // Reference model: requests in flight (with stale flag) and buffered words.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } infl_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    infl_t       inflight[$];
    ent_t        mbuf[$];
    logic [31:0] m_pc;

    vec_t vt[13];

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        imem.gnt       = 1'b0;
        imem.rvalid    = 1'b0;
        imem.rdata     = '0;

        // gnt rv rdy redir rdata rpc | req addr | valid instr pc
        vt[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0, 32'h0);
        vt[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, W0,    32'h0,   1'b1, 32'h4,   1'b0, 32'h0, 32'h0);
        vt[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, W1,    32'h0,   1'b0, 32'h8,   1'b1, W0,    32'h0);
        vt[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,   1'b1, 32'h8,   1'b1, W1,    32'h4);
        vt[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, W2,    32'h0,   1'b0, 32'hc,   1'b1, W1,    32'h4);
        vt[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,   1'b0, 32'hc,   1'b1, W1,    32'h4);
        vt[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,   1'b0, 32'hc,   1'b1, W1,    32'h4);
        vt[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,   1'b1, 32'hc,   1'b1, W2,    32'h8);
        vt[8]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h103, 1'b0, 32'h10,  1'b1, W2,    32'h8);
        vt[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, WS,    32'h0,   1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        vt[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, W0,    32'h0,   1'b1, 32'h104, 1'b0, 32'h0, 32'h0);
        vt[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,   1'b1, 32'h104, 1'b1, W0,    32'h100);
        vt[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0, 32'h0);
`ifdef FETCH_BYPASS_EN
        vt[1].e_valid  = 1'b1; vt[1].e_instr  = W0; vt[1].e_pc  = 32'h0;
        vt[10].e_valid = 1'b1; vt[10].e_instr = W0; vt[10].e_pc = 32'h100;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset imem_req", 32'(imem.req), 32'h0);
        check_head("reset", 1'b0, 32'h0, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) @(negedge clk);
            imem.gnt       = vt[i].gnt;
            imem.rvalid    = vt[i].rvalid;
            imem.rdata     = vt[i].rdata;
            instr_ready    = vt[i].ready;
            redirect_valid = vt[i].redir;
            redirect_pc    = vt[i].rpc;
            #1;
            chk($sformatf("vec%0d imem_req", i), 32'(imem.req), 32'(vt[i].e_req));
            chk($sformatf("vec%0d imem_addr", i), imem.addr, vt[i].e_addr);
            check_head($sformatf("vec%0d", i), vt[i].e_valid, vt[i].e_instr, vt[i].e_pc);
        end

        // Reset mid-burst: two requests in flight, then a stray return after release.
        @(negedge clk);
        imem.gnt = 1'b1; imem.rvalid = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        imem.gnt = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("midreset imem_req", 32'(imem.req), 32'h0);
        check_head("midreset", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        imem.rvalid = 1'b1; imem.rdata = WS;
        #1;
        chk("release imem_req", 32'(imem.req), 32'h1);
        chk("release imem_addr", imem.addr, RESET_PC);
        check_head("stray0", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        imem.rvalid = 1'b0;
        #1;
        check_head("stray1", 1'b0, 32'h0, 32'h0);
        chk("stray imem_addr", imem.addr, RESET_PC);

        // Randomized run against the queue model.
        m_pc = RESET_PC;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic   exp_req, exp_valid, byp, grant, ret, pop;
            infl_t  e;
            ent_t   hd;
            @(negedge clk);
            imem.gnt       = ($urandom_range(0, 3) != 0);
            instr_ready    = ((cyc / 200) % 3 == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            if (inflight.size() > 0) begin
                imem.rvalid = ($urandom_range(0, 2) != 0);
                imem.rdata  = mem_word(inflight[0].addr);
            end else begin
                imem.rvalid = ($urandom_range(0, 15) == 0);
                imem.rdata  = $urandom;
            end
            #1;
            exp_req = (inflight.size() + mbuf.size() < DEPTH) && !redirect_valid;
            byp = 1'b0;
`ifdef FETCH_BYPASS_EN
            byp = (mbuf.size() == 0) && imem.rvalid && (inflight.size() > 0) &&
                  !inflight[0].stale;
`endif
            exp_valid = (mbuf.size() > 0) || byp;
            if (mbuf.size() > 0) hd = mbuf[0];
            else hd = '{instr: imem.rdata, pc: (inflight.size() > 0) ? inflight[0].addr : 32'h0};

            chk("rnd imem_req", 32'(imem.req), 32'(exp_req));
            if (exp_req) chk("rnd imem_addr", imem.addr, m_pc);
            check_head("rnd", exp_valid, hd.instr, hd.pc);

            grant = exp_req && imem.gnt;
            ret   = imem.rvalid && (inflight.size() > 0);
            pop   = exp_valid && instr_ready && !redirect_valid;
            if (pop && mbuf.size() > 0) void'(mbuf.pop_front());
            if (ret) begin
                e = inflight.pop_front();
                if (!e.stale && !redirect_valid && !(byp && pop))
                    mbuf.push_back('{instr: imem.rdata, pc: e.addr});
            end
            if (grant) begin
                inflight.push_back('{addr: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
            if (redirect_valid) begin
                foreach (inflight[k]) inflight[k].stale = 1'b1;
                mbuf.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
